// File: rtl/conv_pkg.sv
// Shared conv-pipeline definitions: config field width, writeback FSM states
// and the 33-bit to 16-bit signed saturation helper.
package conv_pkg;

  localparam int PARAM_WID = 16;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN
  } wb_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    logic signed [15:0] r;
    if (v > 33'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -33'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofmap_writeback_if.sv
// Config, ofmap-stream and output-memory write handshakes of the ofmap writeback block.
interface ofmap_writeback_if #(
  parameter int PARAM_WID = conv_pkg::PARAM_WID,
  parameter int ADDR_WID  = 32
);

  logic [4*PARAM_WID-1:0] cfg_dat;
  logic                   cfg_vld;
  logic                   cfg_rdy;
  logic signed [31:0]     ofmap_dat;
  logic                   ofmap_vld;
  logic                   ofmap_rdy;
  logic                   wr_vld;
  logic                   wr_rdy;
  logic [ADDR_WID-1:0]    wr_addr;
  logic signed [15:0]     wr_dat;
  logic                   done;

  modport master (
    output cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, wr_rdy,
    input  cfg_rdy, ofmap_rdy, wr_vld, wr_addr, wr_dat, done
  );

  modport slave (
    input  cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, wr_rdy,
    output cfg_rdy, ofmap_rdy, wr_vld, wr_addr, wr_dat, done
  );

endinterface

// File: rtl/ofmap_wb_addr_gen.sv
// Six-level loop nest over the ofmap stream (oc0, ox0, oy0, oc1, ox1, oy1, fastest first)
// with the channel-major output address derived combinationally from it.
module ofmap_wb_addr_gen #(
  parameter int OC0       = 4,
  parameter int PARAM_WID = conv_pkg::PARAM_WID,
  parameter int ADDR_WID  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [PARAM_WID-1:0] oy0_cfg,
  input  logic [PARAM_WID-1:0] oc1_cfg,
  input  logic [PARAM_WID-1:0] oy1_cfg,
  output logic [ADDR_WID-1:0]  addr,
  output logic                 last
);

  localparam logic [PARAM_WID-1:0] ONE     = PARAM_WID'(1);
  localparam logic [PARAM_WID-1:0] OC0_MAX = PARAM_WID'(OC0 - 1);

  logic [PARAM_WID-1:0] oc0, ox0, oy0, oc1, ox1, oy1;
  logic                 w_oc0, w_ox0, w_oy0, w_oc1, w_ox1, w_oy1;
  logic                 c_ox0, c_oy0, c_oc1, c_ox1, c_oy1;
  logic [ADDR_WID-1:0]  oc_a, oy_a, ox_a, dim_a;

  always_comb begin
    w_oc0 = (oc0 == OC0_MAX);
    w_ox0 = (ox0 == oy0_cfg - ONE);
    w_oy0 = (oy0 == oy0_cfg - ONE);
    w_oc1 = (oc1 == oc1_cfg - ONE);
    w_ox1 = (ox1 == oy1_cfg - ONE);
    w_oy1 = (oy1 == oy1_cfg - ONE);
    c_ox0 = w_oc0;
    c_oy0 = c_ox0 & w_ox0;
    c_oc1 = c_oy0 & w_oy0;
    c_ox1 = c_oc1 & w_oc1;
    c_oy1 = c_ox1 & w_ox1;
    last  = c_oy1 & w_oy1;
  end

  // Each level steps only when every faster level wraps in the same advance.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      oc0 <= '0;
      ox0 <= '0;
      oy0 <= '0;
      oc1 <= '0;
      ox1 <= '0;
      oy1 <= '0;
    end else if (adv) begin
      oc0 <= w_oc0 ? '0 : oc0 + ONE;
      if (c_ox0) ox0 <= w_ox0 ? '0 : ox0 + ONE;
      if (c_oy0) oy0 <= w_oy0 ? '0 : oy0 + ONE;
      if (c_oc1) oc1 <= w_oc1 ? '0 : oc1 + ONE;
      if (c_ox1) ox1 <= w_ox1 ? '0 : ox1 + ONE;
      if (c_oy1) oy1 <= w_oy1 ? '0 : oy1 + ONE;
    end
  end

  // Working modulo 2^ADDR_WID throughout gives the same result as truncating the full product.
  always_comb begin
    dim_a = ADDR_WID'(oy1_cfg) * ADDR_WID'(oy0_cfg);
    oc_a  = ADDR_WID'(oc1) * ADDR_WID'(OC0) + ADDR_WID'(oc0);
    oy_a  = ADDR_WID'(oy1) * ADDR_WID'(oy0_cfg) + ADDR_WID'(oy0);
    ox_a  = ADDR_WID'(ox1) * ADDR_WID'(oy0_cfg) + ADDR_WID'(ox0);
    addr  = oc_a * dim_a * dim_a + oy_a * dim_a + ox_a;
  end

endmodule

// File: rtl/ofmap_writeback.sv
// Rescales the conv ofmap stream to 16-bit words and writes them channel-major to the output memory.
// Optional ReLU on the input words when OFMAP_WB_RELU_EN is defined.
module ofmap_writeback #(
  parameter int OC0       = 4,
  parameter int PARAM_WID = conv_pkg::PARAM_WID,
  parameter int ADDR_WID  = 32
) (
  input logic            clk,
  input logic            rst_n,
  ofmap_writeback_if.slave bus
);

  import conv_pkg::*;

  wb_state_t            state, state_nxt;
  logic [PARAM_WID-1:0] shift_q, oy0_q, oc1_q, oy1_q;
  logic                 cfg_acc, ofmap_acc, wr_acc, degen, last, done_nxt;
  logic [ADDR_WID-1:0]  addr;
  logic [4:0]           s;
  logic signed [32:0]   x_ext, rnd, shifted;
  logic signed [15:0]   res;
  logic                 shift_unused;

  assign bus.cfg_rdy   = rst_n && (state == WB_IDLE);
  assign bus.ofmap_rdy = (state == WB_RUN) && (!bus.wr_vld || bus.wr_rdy);
  assign cfg_acc       = bus.cfg_vld && bus.cfg_rdy;
  assign ofmap_acc     = bus.ofmap_vld && bus.ofmap_rdy;
  assign wr_acc        = bus.wr_vld && bus.wr_rdy;
  assign degen         = (bus.cfg_dat[4*PARAM_WID-1:3*PARAM_WID] == '0) ||
                         (bus.cfg_dat[3*PARAM_WID-1:2*PARAM_WID] == '0) ||
                         (bus.cfg_dat[2*PARAM_WID-1:PARAM_WID] == '0);
  assign shift_unused  = ^shift_q[PARAM_WID-1:5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.done <= done_nxt;
    end
  end

  // A zero-sized layer skips RUN so done still follows with nothing written.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      WB_IDLE:  if (cfg_acc) state_nxt = degen ? WB_DRAIN : WB_RUN;
      WB_RUN:   if (ofmap_acc && last) state_nxt = WB_DRAIN;
      WB_DRAIN: begin
        if (!bus.wr_vld || wr_acc) begin
          state_nxt = WB_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:  state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      oy0_q   <= '0;
      oc1_q   <= '0;
      oy1_q   <= '0;
    end else if (cfg_acc) begin
      {oy1_q, oc1_q, oy0_q, shift_q} <= bus.cfg_dat;
    end
  end

  ofmap_wb_addr_gen #(
    .OC0      (OC0),
    .PARAM_WID(PARAM_WID),
    .ADDR_WID (ADDR_WID)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cfg_acc),
    .adv    (ofmap_acc),
    .oy0_cfg(oy0_q),
    .oc1_cfg(oc1_q),
    .oy1_cfg(oy1_q),
    .addr   (addr),
    .last   (last)
  );

  // One guard bit above the 32-bit word keeps the rounding add from wrapping.
  always_comb begin
    s     = shift_q[4:0];
    x_ext = {bus.ofmap_dat[31], bus.ofmap_dat};
`ifdef OFMAP_WB_RELU_EN
    if (bus.ofmap_dat[31]) x_ext = '0;
`endif
    rnd = '0;
    if (s != 5'd0) rnd = 33'sd1 <<< (s - 5'd1);
    shifted = (x_ext + rnd) >>> s;
    res     = sat16(shifted);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wr_vld  <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_dat  <= '0;
    end else if (ofmap_acc) begin
      bus.wr_vld  <= 1'b1;
      bus.wr_addr <= addr;
      bus.wr_dat  <= res;
    end else if (wr_acc) begin
      bus.wr_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Self-checking bench for ofmap_writeback: vector-table layers, full-rate, backpressured,
// random, mid-layer reset and zero-sized layers, with a queue-based write scoreboard.
module tb_ofmap_writeback;

  localparam int OC0 = 4;
`ifdef OFMAP_WB_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct packed {
    logic [15:0]        shift;
    logic signed [31:0] x;
    logic signed [15:0] exp_s;
    logic signed [15:0] exp_r;
  } vec_t;

  typedef struct packed {
    logic [31:0]        addr;
    logic signed [15:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ofmap_writeback_if #(.PARAM_WID(16), .ADDR_WID(32)) bus ();

  ofmap_writeback #(.OC0(OC0), .PARAM_WID(16), .ADDR_WID(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    wr_count = 0;
  int    layer_base = 0;
  int    last_wr_cyc = 0;
  int    accept_cyc = 0;
  int    stall_cycles = 0;
  bit    toggle_rdy = 1'b0;
  bit    prev_stall = 1'b0;
  logic [31:0]        prev_addr;
  logic signed [15:0] prev_dat;
  exp_t  sb[$];
  vec_t  vecs[16];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_rdy) bus.wr_rdy = ~bus.wr_rdy;
      else bus.wr_rdy = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int modelDat(input int x, input int sh);
    longint v;
    int s;
    s = sh & 31;
    v = (RELU && x < 0) ? 64'sd0 : longint'(x);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  function automatic int modelAddr(input int idx, input int oy1, input int oc1, input int oy0);
    int t, f, e, d, c, b, a, dim;
    f = idx % OC0;  t = idx / OC0;
    e = t % oy0;    t = t / oy0;
    d = t % oy0;    t = t / oy0;
    c = t % oc1;    t = t / oc1;
    b = t % oy1;    a = t / oy1;
    dim = oy1 * oy0;
    return (c * OC0 + f) * dim * dim + (a * oy0 + d) * dim + (b * oy0 + e);
  endfunction

  // Scoreboard side: every accepted write pops the oldest expectation; stalls must hold the bus.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_vld", bus.wr_vld, 1);
        checkOutput("stall_addr", bus.wr_addr, prev_addr);
        checkOutput("stall_dat", bus.wr_dat, prev_dat);
      end
      if (bus.wr_vld && bus.wr_rdy) begin
        wr_count++;
        last_wr_cyc = cyc;
        checkOutput("write_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("wr_addr", bus.wr_addr, e.addr);
          checkOutput("wr_dat", bus.wr_dat, e.dat);
        end
      end
      if (bus.wr_vld && !bus.wr_rdy) checkOutput("stall_ofmap_rdy", bus.ofmap_rdy, 0);
      prev_stall = bus.wr_vld && !bus.wr_rdy;
      prev_addr  = bus.wr_addr;
      prev_dat   = bus.wr_dat;
    end
  end

  task automatic setVec(input int idx, input int sh, input int x, input int es, input int er);
    vecs[idx].shift = 16'(sh);
    vecs[idx].x     = x;
    vecs[idx].exp_s = 16'(es);
    vecs[idx].exp_r = 16'(er);
  endtask

  task automatic configure(input int oy1, input int oc1, input int oy0, input int sh);
    bit acc = 1'b0;
    bus.cfg_dat = {16'(oy1), 16'(oc1), 16'(oy0), 16'(sh)};
    bus.cfg_vld = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (bus.cfg_rdy) begin
        acc = 1'b1;
        accept_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    bus.cfg_vld = 1'b0;
    checkOutput("cfg_accepted", acc, 1);
    layer_base = wr_count;
  endtask

  task automatic applyStimulus(input int x, input int exp_addr, input int exp_dat);
    bit acc = 1'b0;
    exp_t e;
    bus.ofmap_dat = x;
    bus.ofmap_vld = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (bus.ofmap_rdy) begin
        acc = 1'b1;
        e.addr = 32'(exp_addr);
        e.dat  = 16'(exp_dat);
        sb.push_back(e);
      end else begin
        stall_cycles++;
      end
      @(posedge clk);
      #1;
    end
    bus.ofmap_vld = 1'b0;
    checkOutput("word_accepted", acc, 1);
  endtask

  task automatic waitDone(input int exp_writes, input bit degen);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checkOutput("done_seen", seen, 1);
    if (seen) begin
      if (degen) checkOutput("done_after_cfg", cyc - accept_cyc, 2);
      else checkOutput("done_after_last_wr", cyc - last_wr_cyc, 1);
      checkOutput("write_count", wr_count - layer_base, exp_writes);
      checkOutput("sb_empty", sb.size(), 0);
      @(negedge clk);
      checkOutput("done_one_cycle", bus.done, 0);
      checkOutput("cfg_rdy_idle", bus.cfg_rdy, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runLayer(input int oy1, input int oc1, input int oy0, input int sh, input bit rnd);
    int total, x;
    total = oy1 * oy1 * oy0 * oy0 * oc1 * OC0;
    configure(oy1, oc1, oy0, sh);
    for (int i = 0; i < total; i++) begin
      x = rnd ? int'($urandom_range(400000, 0)) - 200000 : i;
      applyStimulus(x, modelAddr(i, oy1, oc1, oy0), modelDat(x, sh));
    end
    waitDone(total, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cfg_vld   = 1'b0;
    bus.cfg_dat   = '0;
    bus.ofmap_vld = 1'b0;
    bus.ofmap_dat = '0;

    setVec(0, 0, 5, 5, 5);
    setVec(1, 0, -3, -3, 0);
    setVec(2, 0, 70000, 32767, 32767);
    setVec(3, 0, -70000, -32768, 0);
    setVec(4, 2, 6, 2, 2);
    setVec(5, 2, -6, -1, 0);
    setVec(6, 2, 7, 2, 2);
    setVec(7, 2, -7, -2, 0);
    setVec(8, 31, 2147483647, 1, 1);
    setVec(9, 31, int'(32'h8000_0000), -1, 0);
    setVec(10, 31, 0, 0, 0);
    setVec(11, 31, -1, 0, 0);
    setVec(12, 65288, -300000, -1172, 0);
    setVec(13, 65288, 9000000, 32767, 32767);
    setVec(14, 65288, 383, 1, 1);
    setVec(15, 65288, 384, 2, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cfg_rdy", bus.cfg_rdy, 0);
    checkOutput("rst_ofmap_rdy", bus.ofmap_rdy, 0);
    checkOutput("rst_wr_vld", bus.wr_vld, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_wr_addr", bus.wr_addr, 0);
    checkOutput("rst_wr_dat", bus.wr_dat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cfg_rdy", bus.cfg_rdy, 1);
    checkOutput("post_rst_wr_vld", bus.wr_vld, 0);

    @(posedge clk);
    #1;
    bus.ofmap_vld = 1'b1;
    bus.ofmap_dat = 123;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_ofmap_rdy", bus.ofmap_rdy, 0);
    end
    @(posedge clk);
    #1;
    bus.ofmap_vld = 1'b0;

    for (int g = 0; g < 4; g++) begin
      configure(1, 1, 1, int'(vecs[4*g].shift));
      for (int i = 0; i < 4; i++)
        applyStimulus(vecs[4*g+i].x, i, RELU ? int'(vecs[4*g+i].exp_r) : int'(vecs[4*g+i].exp_s));
      if (g == 0) begin
        bus.ofmap_vld = 1'b1;
        bus.ofmap_dat = 999;
        @(negedge clk);
        checkOutput("drain_ofmap_rdy", bus.ofmap_rdy, 0);
        @(posedge clk);
        #1;
        bus.ofmap_vld = 1'b0;
      end
      waitDone(4, 1'b0);
    end

    stall_cycles = 0;
    runLayer(2, 2, 2, 0, 1'b0);
    checkOutput("full_rate_stalls", stall_cycles, 0);

    toggle_rdy   = 1'b1;
    stall_cycles = 0;
    runLayer(2, 2, 2, 0, 1'b0);
    toggle_rdy   = 1'b0;
    checkOutput("toggle_stalls_seen", stall_cycles > 0, 1);

    runLayer(1, 3, 3, 3, 1'b1);

    configure(2, 2, 2, 0);
    for (int i = 0; i < 11; i++) applyStimulus(i, modelAddr(i, 2, 2, 2), i);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_wr_vld", bus.wr_vld, 0);
    checkOutput("midrst_wr_addr", bus.wr_addr, 0);
    checkOutput("midrst_wr_dat", bus.wr_dat, 0);
    checkOutput("midrst_done", bus.done, 0);
    checkOutput("midrst_ofmap_rdy", bus.ofmap_rdy, 0);
    checkOutput("midrst_cfg_rdy", bus.cfg_rdy, 1);
    @(posedge clk);
    #1;

    configure(2, 0, 2, 0);
    waitDone(0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
